// File: rtl/alu_decode_stage.sv
// Registered RV32IM decode/issue stage feeding the one-hot ALU interface.
// Output register plus a one-entry skid buffer keep full throughput under backpressure.
module alu_decode_stage #(
    parameter int XLEN = 32,
    parameter int OPW  = 16,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_in1,
    output logic [XLEN-1:0] out_in2,
    output logic [OPW-1:0]  out_instructions,
    output logic [4:0]      out_rd,
    output logic            out_illegal,
    output logic [CNTW-1:0] issued_count
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_REM  = 4'd12
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [OPW-1:0]  ops;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // rs1 index is resolved by the register-read stage, so its field is not needed here.
    logic unused_rs1_field;
    assign unused_rs1_field = ^in_instr[19:15];

    alu_op_e dec_op;
    logic    dec_legal;
    entry_t  dec;

    // NOTE: every always_comb output gets a default first; a path that skips an assignment would infer a latch.
    always_comb begin
        dec_op    = ALU_ADD;
        dec_legal = 1'b0;
        dec.in1   = in_rs1_data;
        dec.in2   = in_rs2_data;
        dec.rd    = in_instr[11:7];

        case (opcode)
            OPC_OP: begin
                case (funct7)
                    F7_BASE: begin
                        dec_legal = 1'b1;
                        case (funct3)
                            3'b000:  dec_op = ALU_ADD;
                            3'b001:  dec_op = ALU_SLL;
                            3'b010:  dec_op = ALU_SLT;
                            3'b011:  dec_op = ALU_SLTU;
                            3'b100:  dec_op = ALU_XOR;
                            3'b101:  dec_op = ALU_SRL;
                            3'b110:  dec_op = ALU_OR;
                            default: dec_op = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        case (funct3)
                            3'b000: begin
                                dec_op    = ALU_SUB;
                                dec_legal = 1'b1;
                            end
                            3'b101: begin
                                dec_op    = ALU_SRA;
                                dec_legal = 1'b1;
                            end
                            default: dec_legal = 1'b0;
                        endcase
                    end
                    F7_MULDIV: begin
                        case (funct3)
                            3'b000: begin
                                dec_op    = ALU_MUL;
                                dec_legal = 1'b1;
                            end
                            3'b100: begin
                                dec_op    = ALU_DIV;
                                dec_legal = 1'b1;
                            end
                            3'b110: begin
                                dec_op    = ALU_REM;
                                dec_legal = 1'b1;
                            end
                            default: dec_legal = 1'b0;
                        endcase
                    end
                    default: dec_legal = 1'b0;
                endcase
            end

            OPC_OP_IMM: begin
                dec.in2 = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                case (funct3)
                    3'b000: begin
                        dec_op    = ALU_ADD;
                        dec_legal = 1'b1;
                    end
                    3'b010: begin
                        dec_op    = ALU_SLT;
                        dec_legal = 1'b1;
                    end
                    3'b011: begin
                        dec_op    = ALU_SLTU;
                        dec_legal = 1'b1;
                    end
                    3'b100: begin
                        dec_op    = ALU_XOR;
                        dec_legal = 1'b1;
                    end
                    3'b110: begin
                        dec_op    = ALU_OR;
                        dec_legal = 1'b1;
                    end
                    3'b111: begin
                        dec_op    = ALU_AND;
                        dec_legal = 1'b1;
                    end
                    3'b001: begin
                        dec.in2   = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                        dec_op    = ALU_SLL;
                        dec_legal = (funct7 == F7_BASE);
                    end
                    default: begin
                        // Shift-right family: funct7 selects logical vs arithmetic.
                        dec.in2   = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                        dec_op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                endcase
            end

            default: dec_legal = 1'b0;
        endcase

        dec.ops     = dec_legal ? ({{(OPW-1){1'b0}}, 1'b1} << dec_op) : '0;
        dec.illegal = !dec_legal;
    end

    entry_t          out_q, out_n;
    entry_t          skid_q;
    logic            out_valid_q, out_valid_n;
    logic            skid_valid_q, skid_valid_n;
    logic            in_ready_q;
    logic            load_skid;
    logic            in_fire, out_fire, out_free;
    logic            count_en;
    logic [CNTW-1:0] count_q;

    assign in_fire  = in_valid && in_ready_q && !flush;
    assign out_fire = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_fire;
    assign count_en = out_fire && !out_q.illegal && !flush;

    always_comb begin
        out_n        = out_q;
        out_valid_n  = out_valid_q;
        skid_valid_n = skid_valid_q;
        load_skid    = 1'b0;

        if (flush) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end else if (out_free) begin
            // A held skid entry always has priority; in_ready is low whenever it is full.
            if (skid_valid_q) begin
                out_n        = skid_q;
                out_valid_n  = 1'b1;
                skid_valid_n = 1'b0;
            end else if (in_fire) begin
                out_n       = dec;
                out_valid_n = 1'b1;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (in_fire) begin
            load_skid    = 1'b1;
            skid_valid_n = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            count_q      <= '0;
        end else begin
            out_q        <= out_n;
            out_valid_q  <= out_valid_n;
            skid_valid_q <= skid_valid_n;
            in_ready_q   <= !skid_valid_n;
            if (count_en) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // NOTE: the skid payload is storage guarded by skid_valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_q <= dec;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_valid        = out_valid_q;
    assign out_in1          = out_q.in1;
    assign out_in2          = out_q.in2;
    assign out_instructions = out_q.ops;
    assign out_rd           = out_q.rd;
    assign out_illegal      = out_q.illegal;
    assign issued_count     = count_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage: decode sweep, backpressure, flush and reset.
module tb_alu_decode_stage;

    localparam int XLEN = 32;
    localparam int OPW  = 16;
    localparam int CNTW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_in1;
    logic [XLEN-1:0] out_in2;
    logic [OPW-1:0]  out_instructions;
    logic [4:0]      out_rd;
    logic            out_illegal;
    logic [CNTW-1:0] issued_count;

    alu_decode_stage #(.XLEN(XLEN), .OPW(OPW), .CNTW(CNTW)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_instr         (in_instr),
        .in_rs1_data      (in_rs1_data),
        .in_rs2_data      (in_rs2_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_in1          (out_in1),
        .out_in2          (out_in2),
        .out_instructions (out_instructions),
        .out_rd           (out_rd),
        .out_illegal      (out_illegal),
        .issued_count     (issued_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [15:0] ops;
        logic [31:0] in2;
        logic        use_rs2;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [31:0] instr, input logic [15:0] ops, input logic [31:0] in2,
                       input logic use_rs2, input logic [4:0] rd, input logic ill);
        vec_t v;
        v.instr = instr; v.ops = ops; v.in2 = in2; v.use_rs2 = use_rs2; v.rd = rd; v.ill = ill;
        vecs.push_back(v);
    endtask

    // Issue one entry with no backpressure, check the registered result, then let it drain.
    task automatic run_vec(input vec_t v, input logic [31:0] r1, input logic [31:0] r2, input string tag);
        in_instr    = v.instr;
        in_rs1_data = r1;
        in_rs2_data = r2;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " ops"}, 32'(out_instructions), 32'(v.ops));
        check({tag, " illegal"}, 32'(out_illegal), 32'(v.ill));
        check({tag, " in1"}, out_in1, r1);
        if (!v.ill) check({tag, " in2"}, out_in2, v.use_rs2 ? r2 : v.in2);
        check({tag, " rd"}, 32'(out_rd), 32'(v.rd));
        step();
        if (!v.ill) exp_count++;
        check({tag, " count"}, issued_count, exp_count);
        check({tag, " drained"}, 32'(out_valid), 32'd0);
    endtask

    task automatic load_add(input int k);
        in_instr    = 32'h0020_8033 | (32'(k + 4) << 7);
        in_rs1_data = 32'h100 + 32'(k);
        in_rs2_data = 32'h200 + 32'(k);
        in_valid    = 1'b1;
    endtask

    initial begin
        vec_t v;
        int   nxt;
        int   rx;
        logic xin, xout;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_rs1_data = '0; in_rs2_data = '0;
        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset count", issued_count, 32'd0);
        rst = 1'b0;
        step();

        // ADD with no stall
        v.instr = 32'h002081B3; v.ops = 16'h0001; v.in2 = 0; v.use_rs2 = 1; v.rd = 3; v.ill = 0;
        run_vec(v, 32'hFFFFFFFB, 32'd4, "add_nostall");

        // Immediate forms
        add(32'hFFB00093, 16'h0001, 32'hFFFFFFFB, 0, 1, 0); // addi x1,x0,-5
        add(32'h40435293, 16'h0080, 32'd4,        0, 5, 0); // srai x5,x6,4
        // OP sweep
        add(32'h002081B3, 16'h0001, 0, 1, 3, 0);
        add(32'h002091B3, 16'h0020, 0, 1, 3, 0);
        add(32'h0020A1B3, 16'h0100, 0, 1, 3, 0);
        add(32'h0020B1B3, 16'h0200, 0, 1, 3, 0);
        add(32'h0020C1B3, 16'h0004, 0, 1, 3, 0);
        add(32'h0020D1B3, 16'h0040, 0, 1, 3, 0);
        add(32'h0020E1B3, 16'h0008, 0, 1, 3, 0);
        add(32'h0020F1B3, 16'h0010, 0, 1, 3, 0);
        add(32'h402081B3, 16'h0002, 0, 1, 3, 0);
        add(32'h4020D1B3, 16'h0080, 0, 1, 3, 0);
        add(32'h022081B3, 16'h0400, 0, 1, 3, 0);
        add(32'h0220C1B3, 16'h0800, 0, 1, 3, 0);
        add(32'h0220E1B3, 16'h1000, 0, 1, 3, 0);
        // OP-IMM sweep
        add(32'h12308193, 16'h0001, 32'h123, 0, 3, 0);
        add(32'h1230A193, 16'h0100, 32'h123, 0, 3, 0);
        add(32'h1230B193, 16'h0200, 32'h123, 0, 3, 0);
        add(32'h1230C193, 16'h0004, 32'h123, 0, 3, 0);
        add(32'h1230E193, 16'h0008, 32'h123, 0, 3, 0);
        add(32'h1230F193, 16'h0010, 32'h123, 0, 3, 0);
        add(32'h8000F193, 16'h0010, 32'hFFFFF800, 0, 3, 0);
        add(32'h00709193, 16'h0020, 32'd7, 0, 3, 0);
        add(32'h01F0D193, 16'h0040, 32'd31, 0, 3, 0);
        // Illegal encodings
        add(32'h0220D1B3, 16'h0000, 0, 1, 3, 1); // divu
        add(32'h000011B7, 16'h0000, 0, 1, 3, 1); // lui
        add(32'h402091B3, 16'h0000, 0, 1, 3, 1);
        add(32'h0200D193, 16'h0000, 0, 1, 3, 1);
        add(32'h40009193, 16'h0000, 0, 1, 3, 1);

        foreach (vecs[i]) begin
            run_vec(vecs[i], 32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i),
                    $sformatf("vec%0d", i));
        end

        // Backpressure: 4 ADDs, output stalled for 3 edges
        out_ready = 1'b0;
        load_add(0);
        check("bp ready0", 32'(in_ready), 32'd1);
        step();
        check("bp first valid", 32'(out_valid), 32'd1);
        check("bp ready1", 32'(in_ready), 32'd1);
        load_add(1);
        step();
        check("bp ready low", 32'(in_ready), 32'd0);
        check("bp hold1 in1", out_in1, 32'h100);
        load_add(2);
        step();
        check("bp still low", 32'(in_ready), 32'd0);
        check("bp hold2 in1", out_in1, 32'h100);
        check("bp hold2 rd", 32'(out_rd), 32'd4);
        check("bp hold2 valid", 32'(out_valid), 32'd1);
        check("bp no count", issued_count, exp_count);

        out_ready = 1'b1;
        nxt = 2;
        rx  = 0;
        for (int cyc = 0; cyc < 20 && rx < 4; cyc++) begin
            xin  = in_valid && in_ready;
            xout = out_valid && out_ready;
            if (xout) begin
                check($sformatf("bp order%0d in1", rx), out_in1, 32'h100 + 32'(rx));
                check($sformatf("bp order%0d rd", rx), 32'(out_rd), 32'(rx + 4));
                rx++;
                exp_count++;
            end
            step();
            if (xin) begin
                nxt++;
                if (nxt < 4) load_add(nxt);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("bp received", 32'(rx), 32'd4);
        check("bp count", issued_count, exp_count);
        check("bp no dup", 32'(out_valid), 32'd0);

        // Flush with skid full and a simultaneous output transfer
        out_ready = 1'b0;
        load_add(5);
        step();
        load_add(6);
        step();
        check("fl pre valid", 32'(out_valid), 32'd1);
        check("fl pre ready", 32'(in_ready), 32'd0);
        flush     = 1'b1;
        out_ready = 1'b1;
        load_add(7);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl valid", 32'(out_valid), 32'd0);
        check("fl ready", 32'(in_ready), 32'd1);
        check("fl count", issued_count, exp_count);
        step();
        check("fl ignored in", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stall
        out_ready = 1'b0;
        load_add(8);
        step();
        load_add(9);
        step();
        in_valid = 1'b0;
        check("rst pre count", 32'(issued_count != 0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst ready", 32'(in_ready), 32'd1);
        check("rst in1", out_in1, 32'd0);
        check("rst in2", out_in2, 32'd0);
        check("rst ops", 32'(out_instructions), 32'd0);
        check("rst rd", 32'(out_rd), 32'd0);
        check("rst illegal", 32'(out_illegal), 32'd0);
        check("rst count", issued_count, 32'd0);
        #3;
        rst = 1'b0;
        exp_count = 0;
        step();
        check("post rst valid", 32'(out_valid), 32'd0);
        run_vec(vecs[0], 32'h7, 32'h9, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
